// File: rtl/bcd_modn_counter.sv
// Two-digit BCD modulo-N counter with load, up/down stepping, wrap pulses and a
// combinational terminal count for same-cycle cascading of time-of-day stages.
module bcd_modn_counter #(
    parameter int MODULUS = 60,
    parameter int RST_VAL = 0
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       en,
    input  logic       up,
    input  logic       load,
    input  logic [3:0] load_L,
    input  logic [3:0] load_H,
    output logic [3:0] cnt_L,
    output logic [3:0] cnt_H,
    output logic       carry,
    output logic       borrow,
    output logic       tc,
    output logic       load_err
);

    localparam logic [3:0] MAX_H = 4'((MODULUS - 1) / 10);
    localparam logic [3:0] MAX_L = 4'((MODULUS - 1) % 10);
    localparam logic [3:0] RST_H = 4'(RST_VAL / 10);
    localparam logic [3:0] RST_L = 4'(RST_VAL % 10);

    // True when the digit pair is a legal BCD value strictly below MODULUS.
    function automatic logic in_range(input logic [3:0] h, input logic [3:0] l);
        logic digits_ok;
        digits_ok = (h <= 4'd9) && (l <= 4'd9);
        return digits_ok && ((h < MAX_H) || ((h == MAX_H) && (l <= MAX_L)));
    endfunction

    logic       at_max;
    logic       at_zero;
    logic       load_ok;
    logic [3:0] cnt_L_nx;
    logic [3:0] cnt_H_nx;
    logic       carry_nx;
    logic       borrow_nx;
    logic       load_err_nx;

    assign at_max  = (cnt_H == MAX_H) && (cnt_L == MAX_L);
    assign at_zero = (cnt_H == 4'd0) && (cnt_L == 4'd0);
    assign load_ok = in_range(load_H, load_L);
    assign tc      = en & ~load & (up ? at_max : at_zero);

    always_comb begin
        cnt_L_nx    = cnt_L;
        cnt_H_nx    = cnt_H;
        carry_nx    = 1'b0;
        borrow_nx   = 1'b0;
        load_err_nx = 1'b0;
        if (load) begin
            if (load_ok) begin
                cnt_L_nx = load_L;
                cnt_H_nx = load_H;
            end else begin
                load_err_nx = 1'b1;
            end
        end else if (en) begin
            // A corrupted value snaps back to zero silently instead of wrapping.
            if (!in_range(cnt_H, cnt_L)) begin
                cnt_L_nx = 4'd0;
                cnt_H_nx = 4'd0;
            end else if (up) begin
                if (at_max) begin
                    cnt_L_nx = 4'd0;
                    cnt_H_nx = 4'd0;
                    carry_nx = 1'b1;
                end else if (cnt_L == 4'd9) begin
                    cnt_L_nx = 4'd0;
                    cnt_H_nx = cnt_H + 4'd1;
                end else begin
                    cnt_L_nx = cnt_L + 4'd1;
                end
            end else begin
                if (at_zero) begin
                    cnt_L_nx  = MAX_L;
                    cnt_H_nx  = MAX_H;
                    borrow_nx = 1'b1;
                end else if (cnt_L == 4'd0) begin
                    cnt_L_nx = 4'd9;
                    cnt_H_nx = cnt_H - 4'd1;
                end else begin
                    cnt_L_nx = cnt_L - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt_L    <= RST_L;
            cnt_H    <= RST_H;
            carry    <= 1'b0;
            borrow   <= 1'b0;
            load_err <= 1'b0;
        end else begin
            cnt_L    <= cnt_L_nx;
            cnt_H    <= cnt_H_nx;
            carry    <= carry_nx;
            borrow   <= borrow_nx;
            load_err <= load_err_nx;
        end
    end

endmodule

// File: tb/tb_bcd_modn_counter.sv
// Bench for bcd_modn_counter: seven instances (mod 60/24/100 and a 60-60-24 cascade)
// checked every cycle against an integer model plus hand-computed spot values.
module tb_bcd_modn_counter;

    logic clk;
    logic clr_n;
    logic [6:0] en_a;
    logic [6:0] up_a;
    logic [6:0] ld_a;
    logic [6:0][3:0] lh_a;
    logic [6:0][3:0] ll_a;
    logic [6:0][3:0] oh;
    logic [6:0][3:0] ol;
    logic [6:0] oc;
    logic [6:0] ob;
    logic [6:0] ot;
    logic [6:0] oe;

    int modn [7] = '{60, 60, 24, 100, 60, 60, 24};
    int rstv [7] = '{58, 0, 0, 0, 59, 59, 23};
    int mv [7];
    int mc [7];
    int mb [7];
    int me [7];
    int men [7];
    int ncmp = 0;
    int nbad = 0;
    bit chk_on = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    bcd_modn_counter #(.MODULUS(60),  .RST_VAL(58)) u0 (.clk(clk), .clr_n(clr_n), .en(en_a[0]), .up(up_a[0]), .load(ld_a[0]),
        .load_L(ll_a[0]), .load_H(lh_a[0]), .cnt_L(ol[0]), .cnt_H(oh[0]), .carry(oc[0]), .borrow(ob[0]), .tc(ot[0]), .load_err(oe[0]));
    bcd_modn_counter #(.MODULUS(60),  .RST_VAL(0))  u1 (.clk(clk), .clr_n(clr_n), .en(en_a[1]), .up(up_a[1]), .load(ld_a[1]),
        .load_L(ll_a[1]), .load_H(lh_a[1]), .cnt_L(ol[1]), .cnt_H(oh[1]), .carry(oc[1]), .borrow(ob[1]), .tc(ot[1]), .load_err(oe[1]));
    bcd_modn_counter #(.MODULUS(24),  .RST_VAL(0))  u2 (.clk(clk), .clr_n(clr_n), .en(en_a[2]), .up(up_a[2]), .load(ld_a[2]),
        .load_L(ll_a[2]), .load_H(lh_a[2]), .cnt_L(ol[2]), .cnt_H(oh[2]), .carry(oc[2]), .borrow(ob[2]), .tc(ot[2]), .load_err(oe[2]));
    bcd_modn_counter #(.MODULUS(100), .RST_VAL(0))  u3 (.clk(clk), .clr_n(clr_n), .en(en_a[3]), .up(up_a[3]), .load(ld_a[3]),
        .load_L(ll_a[3]), .load_H(lh_a[3]), .cnt_L(ol[3]), .cnt_H(oh[3]), .carry(oc[3]), .borrow(ob[3]), .tc(ot[3]), .load_err(oe[3]));
    // Cascade: seconds -> minutes -> hours, each stage enabled by the previous tc.
    bcd_modn_counter #(.MODULUS(60),  .RST_VAL(59)) u_sec (.clk(clk), .clr_n(clr_n), .en(en_a[4]), .up(up_a[4]), .load(ld_a[4]),
        .load_L(ll_a[4]), .load_H(lh_a[4]), .cnt_L(ol[4]), .cnt_H(oh[4]), .carry(oc[4]), .borrow(ob[4]), .tc(ot[4]), .load_err(oe[4]));
    bcd_modn_counter #(.MODULUS(60),  .RST_VAL(59)) u_min (.clk(clk), .clr_n(clr_n), .en(ot[4] & en_a[5]), .up(up_a[5]), .load(ld_a[5]),
        .load_L(ll_a[5]), .load_H(lh_a[5]), .cnt_L(ol[5]), .cnt_H(oh[5]), .carry(oc[5]), .borrow(ob[5]), .tc(ot[5]), .load_err(oe[5]));
    bcd_modn_counter #(.MODULUS(24),  .RST_VAL(23)) u_hr (.clk(clk), .clr_n(clr_n), .en(ot[5] & en_a[6]), .up(up_a[6]), .load(ld_a[6]),
        .load_L(ll_a[6]), .load_H(lh_a[6]), .cnt_L(ol[6]), .cnt_H(oh[6]), .carry(oc[6]), .borrow(ob[6]), .tc(ot[6]), .load_err(oe[6]));

    // Model terminal count of instance j given its effective enable e.
    function automatic int mtcx(input int j, input int e);
        int hit;
        hit = (up_a[j] == 1'b1) ? int'(mv[j] == modn[j] - 1) : int'(mv[j] == 0);
        return ((e != 0) && (ld_a[j] == 1'b0) && (hit != 0)) ? 1 : 0;
    endfunction

    // Effective enable: cascade stages 5 and 6 are gated by the previous stage's tc.
    function automatic int men_f(input int i);
        int e;
        if (i < 5) return int'(en_a[i]);
        e = int'(en_a[4]);
        for (int j = 4; j < i; j++) e = mtcx(j, e) & int'(en_a[j + 1]);
        return e;
    endfunction

    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int i = 0; i < 7; i++) begin
                mv[i] = rstv[i]; mc[i] = 0; mb[i] = 0; me[i] = 0;
            end
        end else begin
            for (int i = 0; i < 7; i++) men[i] = men_f(i);
            for (int i = 0; i < 7; i++) begin
                mc[i] = 0; mb[i] = 0; me[i] = 0;
                if (ld_a[i]) begin
                    if (ll_a[i] <= 9 && lh_a[i] <= 9 && 10 * int'(lh_a[i]) + int'(ll_a[i]) < modn[i])
                        mv[i] = 10 * int'(lh_a[i]) + int'(ll_a[i]);
                    else
                        me[i] = 1;
                end else if (men[i] != 0) begin
                    if (up_a[i]) begin
                        mc[i] = int'(mv[i] == modn[i] - 1);
                        mv[i] = (mv[i] + 1) % modn[i];
                    end else begin
                        mb[i] = int'(mv[i] == 0);
                        mv[i] = (mv[i] == 0) ? modn[i] - 1 : mv[i] - 1;
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        ncmp++;
        if (act != exp) begin
            nbad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < 7; i++) begin
                chk($sformatf("u%0d cnt_H", i), int'(oh[i]), mv[i] / 10);
                chk($sformatf("u%0d cnt_L", i), int'(ol[i]), mv[i] % 10);
                chk($sformatf("u%0d carry", i), int'(oc[i]), mc[i]);
                chk($sformatf("u%0d borrow", i), int'(ob[i]), mb[i]);
                chk($sformatf("u%0d load_err", i), int'(oe[i]), me[i]);
                chk($sformatf("u%0d tc", i), int'(ot[i]), mtcx(i, men_f(i)));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_v(input string nm, input int i, input int exp);
        chk({nm, " value"}, 10 * int'(oh[i]) + int'(ol[i]), exp);
    endtask

    logic [39:0] dir_pat;

    initial begin
        dir_pat = 40'hF0_3C_A5_96_0F;
        clr_n = 1'b0;
        en_a = 7'b111_1111;
        up_a = 7'b111_1101;
        ld_a = '0;
        lh_a = '0;
        ll_a = '0;
        cyc();
        cyc();
        // Reset state and pre-release terminal counts.
        chk_v("reset u0", 0, 58);
        chk("reset u0 carry", int'(oc[0]), 0);
        chk("reset u0 tc", int'(ot[0]), 0);
        chk_v("reset u_hr", 6, 23);
        chk("cascade hr tc at 23:59:59", int'(ot[6]), 1);
        chk_on = 1;
        clr_n = 1'b1;
        cyc();
        chk_v("u0 first step", 0, 59);
        chk("u0 tc at 59", int'(ot[0]), 1);
        chk("u0 no carry yet", int'(oc[0]), 0);
        chk_v("u1 down wrap", 1, 59);
        chk("u1 borrow", int'(ob[1]), 1);
        chk("cascade 00:00:00", 10000 * (10 * int'(oh[6]) + int'(ol[6])) + 100 * (10 * int'(oh[5]) + int'(ol[5]))
            + 10 * int'(oh[4]) + int'(ol[4]), 0);
        chk("cascade carries", int'({oc[6], oc[5], oc[4]}), 7);
        cyc();
        chk_v("u0 wrap", 0, 0);
        chk("u0 carry", int'(oc[0]), 1);
        chk("u0 tc after wrap", int'(ot[0]), 0);
        chk("u1 borrow one cycle", int'(ob[1]), 0);
        chk("cascade carries drop", int'({oc[6], oc[5], oc[4]}), 0);
        repeat (9) cyc();
        chk_v("u1 down to 49", 1, 49);
        chk_v("u2 at 11", 2, 11);
        repeat (88) cyc();
        chk_v("u3 at 99", 3, 99);
        chk("u3 tc at 99", int'(ot[3]), 1);
        cyc();
        chk_v("u3 wrap", 3, 0);
        chk("u3 carry", int'(oc[3]), 1);
        chk_v("u2 after 100 steps", 2, 4);
        // Loads, with en still high on u0.
        ld_a[0] = 1'b1; lh_a[0] = 4'd4; ll_a[0] = 4'd5;
        ld_a[2] = 1'b1; lh_a[2] = 4'd2; ll_a[2] = 4'd4;
        chk("tc low during load", int'(ot[0]), 0);
        cyc();
        chk_v("load 45", 0, 45);
        chk("load 45 err", int'(oe[0]), 0);
        chk("u2 load 24 err", int'(oe[2]), 1);
        lh_a[0] = 4'd6; ll_a[0] = 4'd0;
        ll_a[2] = 4'd3;
        cyc();
        chk_v("load 60 rejected", 0, 45);
        chk("load 60 err", int'(oe[0]), 1);
        chk_v("u2 load 23", 2, 23);
        lh_a[0] = 4'd0; ll_a[0] = 4'hA;
        ld_a[2] = 1'b0;
        cyc();
        chk_v("load 0A rejected", 0, 45);
        chk("load 0A err", int'(oe[0]), 1);
        chk_v("u2 wrap after load", 2, 0);
        chk("u2 carry after load", int'(oc[2]), 1);
        ld_a[0] = 1'b0;
        cyc();
        chk_v("step after loads", 0, 46);
        chk("err clears", int'(oe[0]), 0);
        // Direction changes every cycle from a fixed pattern.
        for (int k = 0; k < 40; k++) begin
            up_a[0] = dir_pat[k];
            up_a[2] = dir_pat[39 - k];
            up_a[3] = dir_pat[(k * 7) % 40];
            cyc();
        end
        // Asynchronous reset between edges with u0 held at 37.
        up_a[0] = 1'b1;
        ld_a[0] = 1'b1; lh_a[0] = 4'd3; ll_a[0] = 4'd7;
        cyc();
        ld_a[0] = 1'b0; en_a[0] = 1'b0;
        cyc();
        chk_v("u0 holds 37", 0, 37);
        #1 clr_n = 1'b0;
        #1;
        chk_v("async reset u0", 0, 58);
        chk("async reset flags", int'({oc[0], ob[0], oe[0]}), 0);
        chk_v("async reset u1", 1, 0);
        cyc();
        chk_v("held in reset", 0, 58);
        en_a[0] = 1'b1;
        clr_n = 1'b1;
        cyc();
        chk_v("resume after reset", 0, 59);
        cyc();
        chk_v("wrap after reset", 0, 0);
        chk("carry after reset", int'(oc[0]), 1);
        repeat (3) cyc();
        chk_on = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end

endmodule
